// File: rtl/led_sequencer.sv
// Six-LED pattern driver: debounced button cycles through shift, bounce,
// binary count and PWM breathe patterns; LEDs are active low.
`timescale 1ns/1ps
module led_sequencer #(
  parameter int DIV      = 27000000 / 8,
  parameter int DEBOUNCE = 270000,
  parameter int STEP     = 52734,
  parameter int PWM_BITS = 8
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       btn_n,
  output logic [5:0] leds,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    SHIFT   = 2'd0,
    BOUNCE  = 2'd1,
    COUNT   = 2'd2,
    BREATHE = 2'd3
  } mode_t;

  localparam int TW = $clog2(DIV);
  localparam int DW = $clog2(DEBOUNCE);
  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [TW-1:0]       TICK_LAST = TW'(DIV - 1);
  localparam logic [DW-1:0]       DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  logic [1:0]          sync_ff;
  logic                db_level;
  logic [DW-1:0]       db_cnt;
  logic                press;

  mode_t               mode_q;
  mode_t               next_mode;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [5:0]          pat;
  logic [2:0]          pos;
  logic [2:0]          next_pos;
  logic                pos_up;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                duty_up;
  logic [SW-1:0]       step_cnt;

  // NOTE: the synchronizer resets to the released level so leaving reset
  // with the button held never looks like a press.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      sync_ff  <= 2'b11;
      db_level <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old
      // values of its neighbours, which the two-stage synchronizer relies on.
      sync_ff <= {sync_ff[0], btn_n};
      press   <= 1'b0;
      if (sync_ff[1] != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sync_ff[1];
          db_cnt   <= '0;
          press    <= db_level;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    next_mode = mode_t'(mode_q + 2'd1);
    next_pos  = pos_up ? pos + 3'd1 : pos - 3'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      mode_q   <= SHIFT;
      tick_cnt <= '0;
      pat      <= 6'b000001;
      pos      <= '0;
      pos_up   <= 1'b1;
      pwm_cnt  <= '0;
      duty     <= '0;
      duty_up  <= 1'b1;
      step_cnt <= '0;
      leds     <= 6'b111110;
    end else begin
      leds <= ~pat;
      if (press) begin
        // A press overrides any tick in the same cycle and restarts the new pattern.
        mode_q   <= next_mode;
        tick_cnt <= '0;
        pos      <= '0;
        pos_up   <= 1'b1;
        pwm_cnt  <= '0;
        duty     <= '0;
        duty_up  <= 1'b1;
        step_cnt <= '0;
        pat      <= (next_mode == COUNT || next_mode == BREATHE) ? 6'b000000 : 6'b000001;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        case (mode_q)
          SHIFT:   if (tick) pat <= {pat[4:0], pat[5]};
          BOUNCE:  if (tick) begin
                     pos <= next_pos;
                     pat <= 6'b000001 << next_pos;
                     if (next_pos == 3'd5)      pos_up <= 1'b0;
                     else if (next_pos == 3'd0) pos_up <= 1'b1;
                   end
          COUNT:   if (tick) pat <= pat + 6'd1;
          BREATHE: begin
                     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                     pat     <= {6{pwm_cnt < duty}};
                     if (step_cnt == STEP_LAST) begin
                       step_cnt <= '0;
                       if (duty_up) begin
                         if (duty == DUTY_MAX) begin
                           duty    <= duty - PWM_BITS'(1);
                           duty_up <= 1'b0;
                         end else begin
                           duty <= duty + PWM_BITS'(1);
                         end
                       end else begin
                         if (duty == '0) begin
                           duty    <= duty + PWM_BITS'(1);
                           duty_up <= 1'b1;
                         end else begin
                           duty <= duty - PWM_BITS'(1);
                         end
                       end
                     end else begin
                       step_cnt <= step_cnt + SW'(1);
                     end
                   end
        endcase
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: expected LED/mode values are queued from a
// bench-side model and popped at each sample point.
`timescale 1ns/1ps
module tb_led_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic       btn_n;
  logic [5:0] leds;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  led_sequencer #(
    .DIV      (4),
    .DEBOUNCE (3),
    .STEP     (2),
    .PWM_BITS (3)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .btn_n     (btn_n),
    .leds      (leds),
    .mode      (mode)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic expect6(input logic [5:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [5:0] obs);
    logic [5:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed=%b expected=<none queued>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  // Button held low long enough for one press; returns just after mode updates.
  task automatic press();
    btn_n = 1'b0;
    cycles(6);
    btn_n = 1'b1;
  endtask

  function automatic int tri_wave(input int j);
    int r;
    r = j % 14;
    return (r <= 7) ? r : 14 - r;
  endfunction

  initial begin
    int seq[12];
    logic [5:0] one;
    int n;
    seq = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    one = 6'b000001;

    // Reset, then assert it again mid-count
    sys_reset = 1'b1;
    btn_n     = 1'b1;
    cycles(2);
    sys_reset = 1'b0;
    expect6(6'b111101);
    cycles(5);
    chk("shift_first_tick", leds);
    cycles(2);
    sys_reset = 1'b1;
    #1;
    expect6(6'b111110);
    chk("reset_leds", leds);
    expect6(6'b000000);
    chk("reset_mode", {4'b0, mode});
    cycles(1);
    sys_reset = 1'b0;

    // Shift sequence from reset: one step every 4 cycles, back to LED0 after 6
    cycles(1);
    for (int k = 1; k <= 6; k++) expect6(~(one << (k % 6)));
    for (int k = 1; k <= 6; k++) begin
      cycles(4);
      chk($sformatf("shift_k%0d", k), leds);
    end

    // Short glitch is filtered
    btn_n = 1'b0;
    cycles(2);
    btn_n = 1'b1;
    cycles(8);
    expect6(6'b000000);
    chk("glitch_mode", {4'b0, mode});

    // Real press: mode changes exactly 6 cycles after the falling edge
    btn_n = 1'b0;
    cycles(5);
    expect6(6'b000000);
    chk("press_mode_early", {4'b0, mode});
    cycles(1);
    expect6(6'b000001);
    chk("press_mode_bounce", {4'b0, mode});

    // Bounce pattern; release the button partway through
    for (int k = 0; k < 12; k++) expect6(~(one << seq[k]));
    cycles(1);
    chk("bounce_k0", leds);
    cycles(3);
    btn_n = 1'b1;
    cycles(1);
    chk("bounce_k1", leds);
    for (int k = 2; k < 12; k++) begin
      cycles(4);
      chk($sformatf("bounce_k%0d", k), leds);
    end
    expect6(6'b000001);
    chk("release_mode", {4'b0, mode});

    // Count with wrap at 64
    press();
    expect6(6'b000010);
    chk("count_mode", {4'b0, mode});
    expect6(6'b111111);
    cycles(1);
    chk("count_k0", leds);
    for (int k = 1; k <= 64; k++) begin
      expect6(~6'(k));
      cycles(4);
      chk($sformatf("count_k%0d", k), leds);
    end

    // Breathe: triangle duty stepping every 2 cycles over an 8-cycle PWM period
    press();
    expect6(6'b000011);
    chk("breathe_mode", {4'b0, mode});
    for (int m = 1; m <= 40; m++) begin
      if (m == 1) begin
        expect6(6'b111111);
      end else begin
        n = m - 2;
        expect6(((n % 8) < tri_wave(n / 2)) ? 6'b000000 : 6'b111111);
      end
      cycles(1);
      chk($sformatf("breathe_m%0d", m), leds);
    end

    // Press in breathe wraps to shift
    press();
    expect6(6'b000000);
    chk("wrap_mode", {4'b0, mode});
    expect6(6'b111110);
    cycles(1);
    chk("wrap_leds_entry", leds);
    expect6(6'b111101);
    cycles(4);
    chk("wrap_leds_tick", leds);

    // Press event lands on a tick cycle: tick discarded, bounce starts at entry
    cycles(1);
    press();
    expect6(6'b000001);
    chk("collide_mode", {4'b0, mode});
    expect6(6'b111110);
    cycles(1);
    chk("collide_entry", leds);
    expect6(6'b111110);
    cycles(3);
    chk("collide_hold", leds);
    expect6(6'b111101);
    cycles(1);
    chk("collide_first_tick", leds);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
